traffic_sensor_frontend: RTL and testbench

//  Producer side of the intersection controller's A/B traffic-present inputs.
//  - Takes raw, asynchronous, bouncy car-loop detectors for streets A and B.
//  - Counts queued cars per street and drives level A/B = "cars waiting or flowing".
//  - Removes cars from a street's count at a fixed rate while that street shows green.
//  - Sits between the loop-detector pins and the controller; green status is fed back from the controller.

---
 rtl/traffic_pkg.sv | 12 +
 rtl/sensor_channel.sv | 98 +++++++++
 rtl/traffic_sensor_frontend.sv | 66 ++++++
 tb/tb_traffic_sensor_frontend.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and types for the street A/B traffic sensor front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package traffic_pkg;

  localparam int DEBOUNCE_DEF = 3;  // stable synced cycles before the debounced level moves
  localparam int DEPART_DEF   = 2;  // green cycles per departing car
  localparam int CNT_W_DEF    = 4;  // queue counter width

  typedef logic [CNT_W_DEF-1:0] car_cnt_t;

endpackage

// File: rtl/sensor_channel.sv
// One loop-detector channel: 2-flop sync, debounce, arrival edge, departure timer, queue counter.
// Latency: raw rise captured at edge N -> cnt incremented after edge N+2+DEBOUNCE.
// Backpressure: none; arrivals beyond the counter max are dropped and flagged in ovf.
//
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   raw         asynchronous, bouncy loop detector (rising edge = one car)
//   green       this street's light is green; cars drain at one per DEPART_CYCLES
//   cnt         cars queued on this street
//   ovf         sticky: an arrival was seen while cnt was saturated
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE      = DEBOUNCE_DEF,
  parameter int DEPART_CYCLES = DEPART_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw,
  input  logic             green,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  // Counters need at least one bit even when the terminal count is 0.
  localparam int STAB_W = (DEBOUNCE > 1)      ? $clog2(DEBOUNCE)      : 1;
  localparam int DT_W   = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE - 1);
  localparam logic [DT_W-1:0]   DT_LAST   = DT_W'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic              s1;
  logic              s2;
  logic              deb;
  logic              deb_d;
  logic [STAB_W-1:0] stab;
  logic [DT_W-1:0]   dt;
  logic              arr;
  logic              timing;
  logic              dep;

  // Only the 0->1 transition of the debounced level is a car; release is ignored.
  assign arr    = deb & ~deb_d;
  // The departure timer only runs while there is something to drain.
  assign timing = green & (cnt != '0);
  assign dep    = timing & (dt == DT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      stab  <= '0;
      dt    <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;

      // Any cycle where the synced input agrees with the debounced level
      // restarts the stability count, so short glitches never commit.
      if (s2 == deb) begin
        stab <= '0;
      end else if (stab == STAB_LAST) begin
        deb  <= s2;
        stab <= '0;
      end else begin
        stab <= stab + 1'b1;
      end

      // Losing green mid-count discards the partial departure.
      if (!timing || dep) begin
        dt <= '0;
      end else begin
        dt <= dt + 1'b1;
      end

      // Coincident arrival and departure cancel out.
      case ({arr, dep})
        2'b10: begin
          if (cnt == CNT_MAX) begin
            ovf <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/traffic_sensor_frontend.sv
// Street A/B traffic-present producer for the intersection controller.
// Latency: raw rise at edge N -> cnt/A/B updated after edge N+2+DEBOUNCE; A/B combinational from cnt.
// Backpressure: none; saturating counters with sticky ovf.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   raw_a, raw_b      asynchronous loop detectors
//   green_a, green_b  light status fed back from the controller
//   A, B              cars waiting/flowing on street A / B
//   cnt_a, cnt_b      queued car counts
//   ovf               sticky saturation flags {B, A}
module traffic_sensor_frontend
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE      = DEBOUNCE_DEF,
  parameter int DEPART_CYCLES = DEPART_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_a,
  input  logic             raw_b,
  input  logic             green_a,
  input  logic             green_b,
  output logic             A,
  output logic             B,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [1:0]       ovf
);

  logic ovf_a;
  logic ovf_b;

  // Each channel obeys only its own green, even if both are (illegally) high.
  sensor_channel #(
    .DEBOUNCE      (DEBOUNCE),
    .DEPART_CYCLES (DEPART_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_a),
    .green (green_a),
    .cnt   (cnt_a),
    .ovf   (ovf_a)
  );

  sensor_channel #(
    .DEBOUNCE      (DEBOUNCE),
    .DEPART_CYCLES (DEPART_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_b),
    .green (green_b),
    .cnt   (cnt_b),
    .ovf   (ovf_b)
  );

  assign A   = (cnt_a != '0);
  assign B   = (cnt_b != '0);
  assign ovf = {ovf_b, ovf_a};

endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Bench for traffic_sensor_frontend: table-driven vectors plus hand sequences,
// expectations queued at drive time and compared when the targeted edge has passed.
module tb_traffic_sensor_frontend;
  import traffic_pkg::*;

  logic     clk = 1'b0;
  logic     reset, raw_a, raw_b, green_a, green_b;
  logic     A, B;
  car_cnt_t cnt_a, cnt_b;
  logic [1:0] ovf;

  traffic_sensor_frontend dut (
    .clk     (clk),
    .reset   (reset),
    .raw_a   (raw_a),
    .raw_b   (raw_b),
    .green_a (green_a),
    .green_b (green_b),
    .A       (A),
    .B       (B),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         tag;
    car_cnt_t   ea;
    car_cnt_t   eb;
    logic [1:0] eo;
  } exp_t;

  typedef struct {
    logic [4:0] in;   // {raw_a, raw_b, green_a, green_b, reset}
    int         ea;
    int         eb;
    int         eo;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  exp_t cur;
  int   checks = 0;
  int   passed = 0;
  car_cnt_t dep_exp [0:5] = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};

  // Compare every expectation whose target edge has been reached.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.at != cyc) begin
        $display("FAIL t%0d: expectation for cycle %0d reached only at cycle %0d", cur.tag, cur.at, cyc);
      end else if ({cnt_a, cnt_b, A, B, ovf} ===
                   {cur.ea, cur.eb, (cur.ea != 0), (cur.eb != 0), cur.eo}) begin
        passed++;
      end else begin
        $display("FAIL t%0d cyc %0d: got cnt_a=%0d cnt_b=%0d A=%b B=%b ovf=%b, want cnt_a=%0d cnt_b=%0d A=%b B=%b ovf=%b",
                 cur.tag, cyc, cnt_a, cnt_b, A, B, ovf,
                 cur.ea, cur.eb, (cur.ea != 0), (cur.eb != 0), cur.eo);
      end
    end
  end

  // Drive one edge's inputs; optionally queue the state expected after that edge.
  task automatic cycle(input logic [4:0] in, input bit chk, input int tag,
                       input int ea, input int eb, input int eo);
    exp_t e;
    {raw_a, raw_b, green_a, green_b, reset} = in;
    if (chk) begin
      e.at  = cyc + 1;
      e.tag = tag;
      e.ea  = car_cnt_t'(ea);
      e.eb  = car_cnt_t'(eb);
      e.eo  = 2'(eo);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // One clean car on A: the arrival lands during the low phase and the
  // debounced level has fallen again before the task returns.
  task automatic car_a();
    repeat (4) cycle(5'b10000, 1'b0, 0, 0, 0, 0);
    repeat (6) cycle(5'b00000, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic add(input int n, input logic [4:0] in, input int ea, input int eb, input int eo);
    vec_t v;
    v.in = in; v.ea = ea; v.eb = eb; v.eo = eo;
    repeat (n) vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    {raw_a, raw_b, green_a, green_b, reset} = 5'b00001;
    @(posedge clk);
    #1;

    // Reset held with raw_a high, then release.
    add(3, 5'b10001, 0, 0, 0);
    add(4, 5'b00000, 0, 0, 0);
    // Arrival latency: rise captured at the first row, count moves on the sixth.
    add(5, 5'b10000, 0, 0, 0);
    add(3, 5'b10000, 1, 0, 0);
    add(4, 5'b00000, 1, 0, 0);
    // Bounce on B: two-cycle glitch ignored, five-cycle press counted.
    add(2, 5'b01000, 1, 0, 0);
    add(6, 5'b00000, 1, 0, 0);
    add(5, 5'b01000, 1, 0, 0);
    add(4, 5'b00000, 1, 1, 0);
    for (int i = 0; i < vecs.size(); i++)
      cycle(vecs[i].in, 1'b1, 100 + i, vecs[i].ea, vecs[i].eb, vecs[i].eo);

    // Departures: 3 cars drained at one per two green cycles.
    car_a();
    car_a();
    cycle(5'b00000, 1'b1, 400, 3, 1, 0);
    for (int i = 0; i < 6; i++)
      cycle(5'b00100, 1'b1, 401 + i, dep_exp[i], 1, 0);
    repeat (2) cycle(5'b00100, 1'b1, 407, 0, 1, 0);

    // Green only one cycle in three never completes a departure.
    car_a();
    for (int k = 0; k < 3; k++) begin
      cycle(5'b00100, 1'b1, 410 + k, 1, 1, 0);
      repeat (2) cycle(5'b00000, 1'b1, 410 + k, 1, 1, 0);
    end

    // Arrival coincident with a departure leaves the count unchanged.
    car_a();
    repeat (4) cycle(5'b10000, 1'b1, 500, 2, 1, 0);
    repeat (2) cycle(5'b10100, 1'b1, 501, 2, 1, 0);
    cycle(5'b00000, 1'b1, 502, 2, 1, 0);
    repeat (6) cycle(5'b00000, 1'b0, 0, 0, 0, 0);

    // Saturation, from a mid-state reset.
    cycle(5'b00001, 1'b1, 600, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      car_a();
      if (i == 15) cycle(5'b00000, 1'b1, 601, 15, 0, 0);
    end
    cycle(5'b00000, 1'b1, 602, 15, 0, 1);
    cycle(5'b00100, 1'b1, 603, 15, 0, 1);
    cycle(5'b00100, 1'b1, 604, 14, 0, 1);
    cycle(5'b00000, 1'b1, 605, 14, 0, 1);
    cycle(5'b00001, 1'b1, 606, 0, 0, 0);
    cycle(5'b00000, 1'b1, 607, 0, 0, 0);

    repeat (2) cycle(5'b00000, 1'b0, 0, 0, 0, 0);
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      $display("FAIL t%0d: expectation for cycle %0d never compared", cur.tag, cur.at);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
